ser2par_align_ctrl: RTL and testbench
=====================================

Name: ser2par_align_ctrl

Overview:
Receive-side word-alignment controller for the 10-bit SERDES link. It shifts in the serial stream and hunts for the K28.5 comma to fix the 10-bit word boundary. It verifies the boundary over consecutive commas, then delivers aligned parallel words with a valid strobe. It sits between the serial line and the ser2par consumer logic, and flags loss of alignment.

Parameters:
WIDTH, 10, word width in bits (fixed by the 8b10b coding; other values unsupported)
COMMA_P, 10'b0011111010, K28.5 comma, RD- form
COMMA_N, 10'b1100000101, K28.5 comma, RD+ form
LOCK_CNT, 3, consecutive aligned commas required to enter LOCKED (range 1..15)
LOSS_CNT, 4, consecutive misaligned commas that drop LOCKED (range 1..15)

Ports:
clk  input  1  single system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
SER_EN  input  1  bit qualifier; INP_SER is sampled only when high
INP_SER  input  1  serial data, MSB of each word first
OUT_PAR  output  10  last aligned word, MSB = first received bit
PAR_VALID  output  1  one-cycle strobe; OUT_PAR is new
COMMA_DET  output  1  qualifies PAR_VALID; the word is COMMA_P or COMMA_N
LOCKED  output  1  high while the state is LOCKED
ALIGN_ERR  output  1  one-cycle pulse on a comma found off the current boundary (VERIFY or LOCKED)

Behaviour:
- Reset, synchronous and dominant over all other inputs:
  - shift register SR = 0, phase PH = 0, fill count = 0, state = HUNT, both counters = 0.
  - All outputs are 0 in the cycle after the reset edge.
  - Reset mid-word discards any partial word.
- Shifting: on an edge with SER_EN = 1, SR <= {SR[8:0], INP_SER}; PH <= (PH == 9) ? 0 : PH + 1; fill count saturates at 10.
- SER_EN = 0: SR, PH, state and counters hold; PAR_VALID, COMMA_DET and ALIGN_ERR are 0.
- Match: the next SR value equals COMMA_P or COMMA_N AND the fill count (including this bit) is at least 10. No match is possible from reset zero-fill.
- Boundary: an enabled bit for which the next PH equals 0.
- Outputs are registered and appear in the cycle after the edge that samples the bit. Latency is 1 clk after the 10th bit of a word.
- HUNT:
  - On a match: PH <= 0 (this bit closes a word), cnt <= 1, go to VERIFY.
  - PAR_VALID stays 0.
- VERIFY:
  - Match on a boundary: cnt++. When cnt reaches LOCK_CNT, go to LOCKED and set err_cnt = 0.
  - Non-comma word on a boundary: go to HUNT, cnt = 0.
  - Match off the boundary: re-anchor with PH <= 0 and cnt <= 1; pulse ALIGN_ERR.
  - PAR_VALID stays 0.
- LOCKED:
  - Every boundary: OUT_PAR <= word and PAR_VALID = 1. COMMA_DET = 1 if the word is a comma.
  - Aligned comma: err_cnt <= 0.
  - Match off the boundary: err_cnt++ and pulse ALIGN_ERR; PH is not re-anchored.
  - When err_cnt reaches LOSS_CNT: go to HUNT, LOCKED = 0 in the next cycle, cnt = 0. The same bit does not re-anchor.
- OUT_PAR holds its last value between strobes. It is cleared only by reset.
- Simultaneous boundary and match in LOCKED: the word is emitted with COMMA_DET = 1 and counts as aligned.
- Counters are 4 bits and saturate; they never wrap.
- LOCK_CNT = 1: the first match goes HUNT -> VERIFY, and the next aligned comma locks.

Decomposition:
- Shared package serdes_pkg holds:
  - WIDTH, COMMA_P, COMMA_N;
  - state encoding HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2.
- One natural sub-module, comma_detect: combinational compare of the 10-bit window against both comma forms, gated by fill >= 10.
- The FSM, PH counter and shift register stay in the top module.

Test Plan:
- Acquisition:
  - Stimulus: after reset, SER_EN = 1, send 3 bits 101, then continuous COMMA_P.
  - Response: first match on bit 13. LOCKED rises the cycle after bit 33. The first PAR_VALID with OUT_PAR = 10'h0FA and COMMA_DET = 1 comes the cycle after bit 43.
- Data while locked:
  - Stimulus: after lock, send 10'h2AA, 10'h155, COMMA_N.
  - Response: three PAR_VALID pulses exactly 10 cycles apart, with OUT_PAR = 2AA, 155, 305. COMMA_DET = 0, 0, 1.
- Slip:
  - Stimulus: while locked on commas, drop one bit.
  - Response: ALIGN_ERR pulses once per comma. LOCKED falls after the 4th misaligned comma. The 5th comma enters VERIFY, and LOCKED returns the cycle after the 7th comma.
- Verify abort:
  - Stimulus: send COMMA_P, COMMA_P, then 10'h2AA.
  - Response: the state returns to HUNT; LOCKED and PAR_VALID stay 0 throughout.
- Gapped input:
  - Stimulus: repeat acquisition with SER_EN toggling 1/0 every cycle.
  - Response: identical word sequence. Each PAR_VALID comes 1 cycle after the enabled 10th bit, and never while SER_EN is 0.
- Reset mid-word:
  - Stimulus: assert reset for 1 cycle mid-word while locked, then send 8 bits 11111010 followed by COMMA_P.
  - Response: all outputs are 0 after reset. There is no match on the 8-bit suffix, and the first match is on the full COMMA_P.

Source files
------------

// File: rtl/serdes_pkg.sv
// serdes_pkg -- shared constants and state encoding for the 10-bit SERDES receive path.
// Revision 1.0
`default_nettype none

package serdes_pkg;

  localparam int WIDTH = 10;

  localparam logic [WIDTH-1:0] COMMA_P = 10'b0011111010;
  localparam logic [WIDTH-1:0] COMMA_N = 10'b1100000101;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Alignment counters are 4 bits and must stick at 15 rather than wrap.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ser2par_align_ctrl_comma_detect.sv
// comma_detect -- flags a K28.5 comma (either disparity) in a completely filled 10-bit window.
// Revision 1.0
`default_nettype none

module comma_detect
  import serdes_pkg::*;
(
  input  logic [WIDTH-1:0] i_win,
  input  logic             i_full,
  output logic             o_match
);

  assign o_match = i_full && ((i_win == COMMA_P) || (i_win == COMMA_N));

endmodule

`default_nettype wire

// File: rtl/ser2par_align_ctrl.sv
// ser2par_align_ctrl -- comma-hunting word aligner: HUNT/VERIFY/LOCKED boundary tracking.
// Revision 1.0
`default_nettype none

module ser2par_align_ctrl
  import serdes_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SER_EN,
  input  logic             INP_SER,
  output logic [WIDTH-1:0] OUT_PAR,
  output logic             PAR_VALID,
  output logic             COMMA_DET,
  output logic             LOCKED,
  output logic             ALIGN_ERR
);

  localparam logic [3:0] LOCK_TH   = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TH   = 4'(LOSS_CNT);
  localparam logic [3:0] PH_LAST   = 4'(WIDTH - 1);
  localparam logic [3:0] FILL_FULL = 4'(WIDTH);

  // Only the last 9 bits are stored; the incoming bit completes the 10-bit window.
  logic [WIDTH-2:0] hist_q, hist_d;
  logic [3:0]       ph_q, ph_d;
  logic [3:0]       fill_q, fill_d;
  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] out_par_q, out_par_d;
  logic             par_valid_q, par_valid_d;
  logic             comma_det_q, comma_det_d;
  logic             align_err_q, align_err_d;

  logic [WIDTH-1:0] win;
  logic [3:0]       fill_nxt;
  logic [3:0]       ph_nxt;
  logic [3:0]       cnt_inc;
  logic [3:0]       err_inc;
  logic             boundary;
  logic             match;

  assign win      = {hist_q, INP_SER};
  assign fill_nxt = (fill_q >= FILL_FULL) ? FILL_FULL : fill_q + 4'd1;
  assign ph_nxt   = (ph_q == PH_LAST) ? 4'd0 : ph_q + 4'd1;
  assign boundary = (ph_nxt == 4'd0);
  assign cnt_inc  = sat_inc4(cnt_q);
  assign err_inc  = sat_inc4(err_cnt_q);

  comma_detect u_comma_detect (
    .i_win   (win),
    .i_full  (fill_nxt >= FILL_FULL),
    .o_match (match)
  );

  always_comb begin
    hist_d      = hist_q;
    ph_d        = ph_q;
    fill_d      = fill_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_cnt_d   = err_cnt_q;
    out_par_d   = out_par_q;
    par_valid_d = 1'b0;
    comma_det_d = 1'b0;
    align_err_d = 1'b0;

    if (SER_EN) begin
      hist_d = win[WIDTH-2:0];
      ph_d   = ph_nxt;
      fill_d = fill_nxt;
      case (state_q)
        ST_HUNT: begin
          if (match) begin
            ph_d    = 4'd0;
            cnt_d   = 4'd1;
            state_d = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (boundary && match) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= LOCK_TH) begin
              state_d   = ST_LOCKED;
              err_cnt_d = 4'd0;
            end
          end else if (boundary) begin
            state_d = ST_HUNT;
            cnt_d   = 4'd0;
          end else if (match) begin
            ph_d        = 4'd0;
            cnt_d       = 4'd1;
            align_err_d = 1'b1;
          end
        end
        ST_LOCKED: begin
          // A comma landing exactly on the boundary is both emitted and treated as aligned.
          if (boundary) begin
            out_par_d   = win;
            par_valid_d = 1'b1;
            comma_det_d = match;
            if (match) begin
              err_cnt_d = 4'd0;
            end
          end else if (match) begin
            err_cnt_d   = err_inc;
            align_err_d = 1'b1;
            if (err_inc >= LOSS_TH) begin
              state_d = ST_HUNT;
              cnt_d   = 4'd0;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q      <= '0;
      ph_q        <= 4'd0;
      fill_q      <= 4'd0;
      state_q     <= ST_HUNT;
      cnt_q       <= 4'd0;
      err_cnt_q   <= 4'd0;
      out_par_q   <= '0;
      par_valid_q <= 1'b0;
      comma_det_q <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      ph_q        <= ph_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
      out_par_q   <= out_par_d;
      par_valid_q <= par_valid_d;
      comma_det_q <= comma_det_d;
      align_err_q <= align_err_d;
    end
  end

  assign OUT_PAR   = out_par_q;
  assign PAR_VALID = par_valid_q;
  assign COMMA_DET = comma_det_q;
  assign ALIGN_ERR = align_err_q;
  assign LOCKED    = (state_q == ST_LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_ser2par_align_ctrl.sv
// tb_ser2par_align_ctrl -- directed stimulus with a cycle-stamped scoreboard for the word aligner.
// Revision 1.0
`default_nettype none

module tb_ser2par_align_ctrl;
  import serdes_pkg::*;

  logic             clk     = 1'b0;
  logic             reset   = 1'b0;
  logic             SER_EN  = 1'b0;
  logic             INP_SER = 1'b0;
  logic [WIDTH-1:0] OUT_PAR;
  logic             PAR_VALID;
  logic             COMMA_DET;
  logic             LOCKED;
  logic             ALIGN_ERR;

  always #5 clk = ~clk;

  ser2par_align_ctrl #(.LOCK_CNT(3), .LOSS_CNT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .SER_EN    (SER_EN),
    .INP_SER   (INP_SER),
    .OUT_PAR   (OUT_PAR),
    .PAR_VALID (PAR_VALID),
    .COMMA_DET (COMMA_DET),
    .LOCKED    (LOCKED),
    .ALIGN_ERR (ALIGN_ERR)
  );

  typedef struct { int cyc; logic [9:0] d; logic cd; } exp_t;
  typedef struct { int bitn; int kind; logic [9:0] d; logic cd; } plan_t;

  localparam int K_WORD = 0;
  localparam int K_ERR  = 1;
  localparam int K_LOCK = 2;

  exp_t  q_word[$];
  exp_t  q_err[$];
  exp_t  q_lock[$];
  plan_t plan[$];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   bitn  = 0;
  logic in_reset  = 1'b1;
  logic lock_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got an event at cycle %0d expected none", name, cyc);
  endtask

  // Monitor: every DUT event is matched against the oldest expectation of its kind.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (in_reset) begin
        lock_prev = LOCKED;
      end else begin
        if (PAR_VALID) begin
          if (q_word.size() == 0) unexpected("PAR_VALID");
          else begin
            e = q_word.pop_front();
            chk("word cycle", cyc, e.cyc);
            chk("OUT_PAR", int'(OUT_PAR), int'(e.d));
            chk("COMMA_DET", int'(COMMA_DET), int'(e.cd));
          end
        end else if (COMMA_DET) begin
          unexpected("COMMA_DET without PAR_VALID");
        end
        if (ALIGN_ERR) begin
          if (q_err.size() == 0) unexpected("ALIGN_ERR");
          else begin
            e = q_err.pop_front();
            chk("ALIGN_ERR cycle", cyc, e.cyc);
          end
        end
        if (LOCKED !== lock_prev) begin
          if (q_lock.size() == 0) unexpected("LOCKED change");
          else begin
            e = q_lock.pop_front();
            chk("LOCKED cycle", cyc, e.cyc);
            chk("LOCKED value", int'(LOCKED), int'(e.d[0]));
          end
          lock_prev = LOCKED;
        end
        while (q_word.size() > 0 && q_word[0].cyc < cyc) begin
          e = q_word.pop_front();
          chk("missing PAR_VALID at cycle", cyc, e.cyc);
        end
        while (q_err.size() > 0 && q_err[0].cyc < cyc) begin
          e = q_err.pop_front();
          chk("missing ALIGN_ERR at cycle", cyc, e.cyc);
        end
        while (q_lock.size() > 0 && q_lock[0].cyc < cyc) begin
          e = q_lock.pop_front();
          chk("missing LOCKED change at cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic add(input int b, input int kind, input logic [9:0] d, input logic cd);
    plan_t p;
    p.bitn = b; p.kind = kind; p.d = d; p.cd = cd;
    plan.push_back(p);
  endtask

  // Drive one enabled bit; expectations planned for this bit index are pushed with its result cycle.
  task automatic send_bit(input logic b, input logic gap);
    exp_t e;
    @(negedge clk);
    SER_EN  = 1'b1;
    INP_SER = b;
    bitn++;
    for (int i = 0; i < plan.size(); i++) begin
      if (plan[i].bitn == bitn) begin
        e.cyc = cyc + 1; e.d = plan[i].d; e.cd = plan[i].cd;
        case (plan[i].kind)
          K_WORD:  q_word.push_back(e);
          K_ERR:   q_err.push_back(e);
          default: q_lock.push_back(e);
        endcase
      end
    end
    if (gap) begin
      @(negedge clk);
      SER_EN  = 1'b0;
      INP_SER = ~b;
    end
  endtask

  task automatic send_word(input logic [9:0] w, input int n, input logic gap);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      SER_EN  = 1'b0;
      INP_SER = 1'b0;
    end
  endtask

  task automatic drain_check(input string name);
    idle(3);
    chk({name, " pending words"}, q_word.size(), 0);
    chk({name, " pending align errors"}, q_err.size(), 0);
    chk({name, " pending lock changes"}, q_lock.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_reset = 1'b1;
    reset    = 1'b1;
    SER_EN   = 1'b0;
    INP_SER  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("reset OUT_PAR", int'(OUT_PAR), 0);
    chk("reset PAR_VALID", int'(PAR_VALID), 0);
    chk("reset COMMA_DET", int'(COMMA_DET), 0);
    chk("reset LOCKED", int'(LOCKED), 0);
    chk("reset ALIGN_ERR", int'(ALIGN_ERR), 0);
    q_word.delete(); q_err.delete(); q_lock.delete(); plan.delete();
    bitn = 0;
    @(posedge clk);
    in_reset = 1'b0;
  endtask

  task automatic acquire(input logic gap);
    add(33, K_LOCK, 10'd1, 1'b0);
    add(43, K_WORD, 10'h0FA, 1'b1);
    send_word(10'b0000000101, 3, gap);
    repeat (4) send_word(COMMA_P, 10, gap);
  endtask

  initial begin
    // Acquisition, locked data, then a one-bit slip.
    do_reset();
    acquire(1'b0);
    add(53, K_WORD, 10'h2AA, 1'b0);
    add(63, K_WORD, 10'h155, 1'b0);
    add(73, K_WORD, 10'h305, 1'b1);
    send_word(10'h2AA, 10, 1'b0);
    send_word(10'h155, 10, 1'b0);
    send_word(COMMA_N, 10, 1'b0);
    add(83, K_WORD, 10'h0FA, 1'b1);
    add(92, K_ERR, 10'd0, 1'b0);
    add(93, K_WORD, 10'h1F4, 1'b0);
    add(102, K_ERR, 10'd0, 1'b0);
    add(103, K_WORD, 10'h1F4, 1'b0);
    add(112, K_ERR, 10'd0, 1'b0);
    add(113, K_WORD, 10'h1F4, 1'b0);
    add(122, K_ERR, 10'd0, 1'b0);
    add(122, K_LOCK, 10'd0, 1'b0);
    add(152, K_LOCK, 10'd1, 1'b0);
    send_word(COMMA_P, 10, 1'b0);
    send_word(COMMA_P, 9, 1'b0);
    repeat (6) send_word(COMMA_P, 10, 1'b0);
    drain_check("slip");

    // Verify abort: a data word on the boundary sends the hunt back to the start.
    do_reset();
    add(60, K_LOCK, 10'd1, 1'b0);
    send_word(COMMA_P, 10, 1'b0);
    send_word(COMMA_P, 10, 1'b0);
    send_word(10'h2AA, 10, 1'b0);
    repeat (3) send_word(COMMA_P, 10, 1'b0);
    drain_check("verify abort");

    // Gapped acquisition, then reset mid-word.
    do_reset();
    acquire(1'b1);
    send_word(10'h2AA, 5, 1'b1);
    do_reset();
    add(38, K_LOCK, 10'd1, 1'b0);
    add(48, K_WORD, 10'h0FA, 1'b1);
    send_word(COMMA_P, 8, 1'b0);
    repeat (4) send_word(COMMA_P, 10, 1'b0);
    drain_check("reset mid-word");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout at cycle %0d expected completion", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
